// File: rtl/encoder_rpm_meter_if.sv
// encoder_rpm_meter_if: encoder inputs and RPM/error outputs of the speed meter.
interface encoder_rpm_meter_if;
    logic              ENC_A;
    logic              ENC_B;
    logic signed [15:0] RPM_Medidas;
    logic              RPM_valid;
    logic              ENC_ERR;
    logic [7:0]        ERR_COUNT;
    modport master (output ENC_A, ENC_B, input RPM_Medidas, RPM_valid, ENC_ERR, ERR_COUNT);
    modport slave  (input ENC_A, ENC_B, output RPM_Medidas, RPM_valid, ENC_ERR, ERR_COUNT);
endinterface

// File: rtl/encoder_rpm_meter.sv
// encoder_rpm_meter: 4x quadrature decoder, gated signed count and 2-stage
// count-to-RPM scaling with symmetric saturation.
module encoder_rpm_meter #(
    parameter int WINDOW_CYCLES = 250000,
    parameter int RPM_NUM       = 250,
    parameter int RPM_SHIFT     = 0,
    parameter int COUNT_W       = 16
) (
    input logic                clk,
    input logic                reset,
    encoder_rpm_meter_if.slave enc
);
    localparam int PW = COUNT_W + 32;
    localparam int WW = $clog2(WINDOW_CYCLES);
    localparam logic signed [PW-1:0] NUM  = PW'(RPM_NUM);
    localparam logic signed [PW-1:0] RMAX = PW'(32767);
    localparam logic signed [PW-1:0] RMIN = -RMAX;

    logic [1:0]                r_sa, r_sb, r_p, r_prime;
    logic [WW-1:0]             r_win;
    logic signed [COUNT_W-1:0] r_acc;
    logic signed [PW-1:0]      r_prod;
    logic                      r_s1_vld, r_vld, r_err;
    logic signed [15:0]        r_rpm;
    logic [7:0]                r_err_cnt;
    logic [1:0]                w_s;
    logic                      w_primed, w_fwd, w_rev, w_ill, w_term;
    logic signed [1:0]         w_step;
    logic signed [COUNT_W:0]   w_sum;
    logic signed [COUNT_W-1:0] w_acc_next;
    logic signed [PW-1:0]      w_shift;

    // Forward order is 00->10->11->01, i.e. next = {~b, a}.
    always_comb begin
        w_s        = {r_sa[1], r_sb[1]};
        w_primed   = r_prime == 2'd3;
        w_fwd      = w_s == {~r_p[0], r_p[1]};
        w_rev      = r_p == {~w_s[0], w_s[1]};
        w_ill      = w_primed && ((r_p ^ w_s) == 2'b11);
        w_step     = !w_primed ? 2'sd0 : w_fwd ? 2'sd1 : w_rev ? -2'sd1 : 2'sd0;
        w_sum      = {r_acc[COUNT_W-1], r_acc} + {{(COUNT_W-1){w_step[1]}}, w_step};
        w_acc_next = (w_sum[COUNT_W] ^ w_sum[COUNT_W-1]) ?
                     {w_sum[COUNT_W], {(COUNT_W-1){~w_sum[COUNT_W]}}} : w_sum[COUNT_W-1:0];
        w_term     = w_primed && (r_win == WW'(WINDOW_CYCLES - 1));
        w_shift    = r_prod >>> RPM_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sa      <= '0;
            r_sb      <= '0;
            r_p       <= '0;
            r_prime   <= '0;
            r_win     <= '0;
            r_acc     <= '0;
            r_prod    <= '0;
            r_s1_vld  <= 1'b0;
            r_vld     <= 1'b0;
            r_rpm     <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_sa <= {r_sa[0], enc.ENC_A};
            r_sb <= {r_sb[0], enc.ENC_B};
            r_p  <= w_s;
            if (!w_primed)
                r_prime <= r_prime + 2'd1;
            // Window timing starts only once decoding is live.
            if (w_primed) begin
                r_win <= w_term ? '0 : r_win + WW'(1);
                r_acc <= w_term ? '0 : w_acc_next;
            end
            if (w_ill) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF)
                    r_err_cnt <= r_err_cnt + 8'd1;
            end
            r_s1_vld <= w_term;
            if (w_term)
                r_prod <= PW'(w_acc_next) * NUM;
            r_vld <= r_s1_vld;
            if (r_s1_vld)
                r_rpm <= w_shift > RMAX ? 16'sd32767 : w_shift < RMIN ? -16'sd32767 : w_shift[15:0];
        end
    end

    assign enc.RPM_Medidas = r_rpm;
    assign enc.RPM_valid   = r_vld;
    assign enc.ENC_ERR     = r_err;
    assign enc.ERR_COUNT   = r_err_cnt;
endmodule

// File: tb/tb_encoder_rpm_meter.sv
// tb_encoder_rpm_meter: directed checks of decoding, windowing, scaling,
// saturation, error counting and mid-window reset.
module tb_encoder_rpm_meter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ab  = 2'b00;
    int         cyc = 0;
    int         npulse = 0;
    int         errors = 0;
    int         checks = 0;

    encoder_rpm_meter_if bus ();
    encoder_rpm_meter_if bus_s ();

    encoder_rpm_meter #(.WINDOW_CYCLES(100), .RPM_NUM(3), .RPM_SHIFT(1), .COUNT_W(16))
        u_dut (.clk(clk), .reset(rst), .enc(bus));
    encoder_rpm_meter #(.WINDOW_CYCLES(1000), .RPM_NUM(250), .RPM_SHIFT(0), .COUNT_W(16))
        u_sat (.clk(clk), .reset(rst), .enc(bus_s));

    always #5 clk = ~clk;

    // cyc == k just after the k-th edge following the reset edge.
    always @(posedge clk) begin
        cyc    <= rst ? 0 : cyc + 1;
        npulse <= rst ? 0 : npulse + int'(bus.RPM_valid);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive();
        {bus.ENC_A, bus.ENC_B}     = ab;
        {bus_s.ENC_A, bus_s.ENC_B} = ab;
    endtask

    // dir: 1 forward, -1 reverse, 0 illegal (both channels flip)
    task automatic steps(input int start, input int n, input int dir);
        for (int i = 0; i < n; i++) begin
            at(start + 4 * i);
            ab = dir > 0 ? {~ab[0], ab[1]} : dir < 0 ? {ab[0], ~ab[1]} : ~ab;
            drive();
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_rpm", bus.RPM_Medidas, 0);
        check("rst_vld", int'(bus.RPM_valid), 0);
        check("rst_err", int'(bus.ENC_ERR), 0);
        check("rst_cnt", int'(bus.ERR_COUNT), 0);

        steps(5, 10, 1);
        at(103);
        check("fwd_early_vld", int'(bus.RPM_valid), 0);
        at(104);
        check("fwd_rpm", bus.RPM_Medidas, 15);
        check("fwd_vld", int'(bus.RPM_valid), 1);
        check("fwd_err", int'(bus.ENC_ERR), 0);
        at(105);
        check("fwd_vld_off", int'(bus.RPM_valid), 0);

        steps(106, 10, -1);
        at(204);
        check("rev_rpm", bus.RPM_Medidas, -15);
        check("rev_vld", int'(bus.RPM_valid), 1);
        at(250);
        check("hold_rpm", bus.RPM_Medidas, -15);
        check("hold_vld", int'(bus.RPM_valid), 0);
        at(304);
        check("zero_rpm", bus.RPM_Medidas, 0);
        check("zero_vld", int'(bus.RPM_valid), 1);

        steps(306, 3, 0);
        steps(318, 2, 1);
        at(404);
        check("ill_err", int'(bus.ENC_ERR), 1);
        check("ill_cnt", int'(bus.ERR_COUNT), 3);
        check("ill_rpm", bus.RPM_Medidas, 3);
        check("ill_vld", int'(bus.RPM_valid), 1);

        // Last step lands in the synchroniser so it is decoded on the terminal cycle.
        steps(488, 4, 1);
        at(504);
        check("edge_rpm", bus.RPM_Medidas, 6);
        check("edge_vld", int'(bus.RPM_valid), 1);
        at(604);
        check("edge_next_rpm", bus.RPM_Medidas, 0);

        steps(606, 5, 1);
        at(653);
        pulse_reset();
        check("mid_rst_rpm", bus.RPM_Medidas, 0);
        check("mid_rst_vld", int'(bus.RPM_valid), 0);
        check("mid_rst_err", int'(bus.ENC_ERR), 0);
        check("mid_rst_cnt", int'(bus.ERR_COUNT), 0);
        steps(5, 2, 1);
        at(104);
        check("mid_rst_no_pulse", npulse, 0);
        check("mid_rst_rpm_new", bus.RPM_Medidas, 3);
        check("mid_rst_vld_new", int'(bus.RPM_valid), 1);
        check("mid_rst_cnt_new", int'(bus.ERR_COUNT), 0);

        at(110);
        pulse_reset();
        steps(5, 200, 1);
        at(1004);
        check("sat_pos_rpm", bus_s.RPM_Medidas, 32767);
        check("sat_pos_vld", int'(bus_s.RPM_valid), 1);
        steps(1006, 200, -1);
        at(2004);
        check("sat_neg_rpm", bus_s.RPM_Medidas, -32767);
        check("sat_neg_vld", int'(bus_s.RPM_valid), 1);
        steps(2006, 260, 0);
        at(3050);
        check("sat_err_cnt", int'(bus_s.ERR_COUNT), 255);
        check("sat_err_flag", int'(bus_s.ENC_ERR), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
